kbd_event_decoder: RTL and testbench

KBD_EVENT_DECODER -- requirements
Module: kbd_event_decoder

---
 rtl/kbd_event_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_kbd_event_decoder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_decoder.sv
// rtl/kbd_event_decoder.sv - PS/2 scan-code parser with modifier tracking, repeat filter and event FIFO
//
// Ports:
//   clk, clrn           clock, asynchronous active-low reset
//   ps2_data_in/ready   byte offered by the PS/2 receiver
//   nextdata_n          one-cycle active-low pop strobe back to the receiver
//   ev_valid/ev_ready   event FIFO head handshake (first-word fall-through)
//   ev_code/ext/break/repeat/mods   head event fields (zero while the FIFO is empty)
//   mods                live {caps, alt, ctrl, shift}
//   overflow/ovf_clr    sticky dropped-event flag and its clear
module kbd_event_decoder #(
    parameter int DEPTH     = 8,
    parameter int HOLDOFF   = 2500000,
    parameter int REPEAT_EN = 0
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] ps2_data_in,
    input  logic       ps2_ready,
    output logic       nextdata_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_repeat,
    output logic [3:0] ev_mods,
    output logic [3:0] mods,
    output logic       overflow,
    input  logic       ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LD  = HW'(HOLDOFF);

    typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXTBRK, ST_SKIP} state_t;

    state_t       state_q, state_d;
    logic [2:0]   skip_q, skip_d;
    logic         nd_q;
    logic [7:0]   byte_q;
    logic         byte_v_q;
    logic [8:0]   held_q;
    logic         held_v_q;
    // Individually held modifier keys: {ralt, lalt, rctrl, lctrl, rshift, lshift}
    logic [5:0]   modk_q, modk_d;
    logic         caps_q, caps_d;
    logic [HW-1:0] hold_q;
    logic [14:0]  mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]  cnt_q;
    logic         ovf_q;

    logic         key_make, key_brk, key_ext, skip_ev;
    logic [8:0]   key_id;
    logic         is_rep;
    logic [5:0]   mod_hit;
    logic [3:0]   mods_d;
    logic         push_req, push_ok, pop, full, drop;
    logic [14:0]  push_data;

    // Byte parser: decides what the byte latched last cycle means.
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        key_make = 1'b0;
        key_brk  = 1'b0;
        key_ext  = 1'b0;
        skip_ev  = 1'b0;
        if (byte_v_q) begin
            case (state_q)
                ST_IDLE: begin
                    case (byte_q)
                        8'hE0: state_d = ST_EXT;
                        8'hF0: state_d = ST_BRK;
                        8'hE1: begin
                            state_d = ST_SKIP;
                            skip_d  = 3'd7;
                        end
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                        end
                        default: key_make = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_d = ST_EXTBRK;
                    end else begin
                        state_d = ST_IDLE;
                        // E0 12 is the fake shift emitted around extended keys
                        key_make = (byte_q != 8'h12);
                        key_ext  = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    key_brk = 1'b1;
                end
                ST_EXTBRK: begin
                    state_d = ST_IDLE;
                    key_brk = (byte_q != 8'h12);
                    key_ext = 1'b1;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        state_d = ST_IDLE;
                        skip_d  = 3'd0;
                        skip_ev = (skip_q == 3'd1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign key_id = {key_ext, byte_q};
    assign is_rep = key_make && held_v_q && (held_q == key_id);

    assign mod_hit = {key_ext  && byte_q == 8'h11, !key_ext && byte_q == 8'h11,
                      key_ext  && byte_q == 8'h14, !key_ext && byte_q == 8'h14,
                      !key_ext && byte_q == 8'h59, !key_ext && byte_q == 8'h12};

    always_comb begin
        modk_d = modk_q;
        if (key_make)
            modk_d = modk_q | mod_hit;
        else if (key_brk)
            modk_d = modk_q & ~mod_hit;
    end

    assign caps_d = caps_q ^ (key_make && !is_rep && !key_ext && byte_q == 8'h58);
    // Events carry the modifier state including their own effect
    assign mods_d = {caps_d, |modk_d[5:4], |modk_d[3:2], |modk_d[1:0]};

    assign push_req = skip_ev || key_brk || (key_make && !is_rep) ||
                      (key_make && is_rep && (REPEAT_EN != 0) && hold_q == '0);
    assign push_data = {skip_ev ? 8'hE1 : byte_q, key_ext, key_brk, is_rep, mods_d};

    assign full    = (cnt_q == FULL_CNT);
    assign ev_valid = (cnt_q != '0);
    assign pop     = ev_valid && ev_ready;
    // A pop in the same cycle frees the slot the push lands in
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= ST_IDLE;
            skip_q   <= 3'd0;
            nd_q     <= 1'b1;
            byte_q   <= 8'h00;
            byte_v_q <= 1'b0;
            held_q   <= 9'h000;
            held_v_q <= 1'b0;
            modk_q   <= 6'h00;
            caps_q   <= 1'b0;
            hold_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (ps2_ready && nd_q) begin
                byte_q   <= ps2_data_in;
                byte_v_q <= 1'b1;
                nd_q     <= 1'b0;
            end else begin
                byte_v_q <= 1'b0;
                nd_q     <= 1'b1;
            end

            state_q <= state_d;
            skip_q  <= skip_d;
            modk_q  <= modk_d;
            caps_q  <= caps_d;

            if (key_make && !is_rep) begin
                held_q   <= key_id;
                held_v_q <= 1'b1;
            end else if (key_brk && held_v_q && held_q == key_id) begin
                held_q   <= 9'h000;
                held_v_q <= 1'b0;
            end

            if (push_req && (key_make || skip_ev))
                hold_q <= HOLD_LD;
            else if (hold_q != '0)
                hold_q <= hold_q - 1'b1;

            if (push_ok)
                wr_q <= wr_q + 1'b1;
            if (pop)
                rd_q <= rd_q + 1'b1;
            if (push_ok && !pop)
                cnt_q <= cnt_q + 1'b1;
            else if (pop && !push_ok)
                cnt_q <= cnt_q - 1'b1;

            if (drop)
                ovf_q <= 1'b1;
            else if (ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    assign nextdata_n = nd_q;
    assign {ev_code, ev_ext, ev_break, ev_repeat, ev_mods} = ev_valid ? mem[rd_q] : 15'h0000;
    assign mods     = {caps_q, |modk_q[5:4], |modk_q[3:2], |modk_q[1:0]};
    assign overflow = ovf_q;

endmodule

// File: tb/tb_kbd_event_decoder.sv
// tb/tb_kbd_event_decoder.sv - randomized self-checking bench for kbd_event_decoder
module tb_kbd_event_decoder;
    localparam int HO = 15;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_ready = 1'b0;

    logic       nd_a, nd_b, ev_valid_a, ev_valid_b, ev_ready_a, ev_ready_b;
    logic [7:0] ev_code_a, ev_code_b;
    logic       ev_ext_a, ev_ext_b, ev_break_a, ev_break_b, ev_repeat_a, ev_repeat_b;
    logic [3:0] ev_mods_a, ev_mods_b, mods_a, mods_b;
    logic       overflow_a, overflow_b, ovf_clr_a, ovf_clr_b;
    logic [14:0] head_a, head_b;

    assign head_a = {ev_code_a, ev_ext_a, ev_break_a, ev_repeat_a, ev_mods_a};
    assign head_b = {ev_code_b, ev_ext_b, ev_break_b, ev_repeat_b, ev_mods_b};

    kbd_event_decoder #(.DEPTH(8), .HOLDOFF(HO), .REPEAT_EN(1)) dut_a (
        .clk(clk), .clrn(clrn), .ps2_data_in(ps2_data), .ps2_ready(ps2_ready),
        .nextdata_n(nd_a), .ev_valid(ev_valid_a), .ev_ready(ev_ready_a),
        .ev_code(ev_code_a), .ev_ext(ev_ext_a), .ev_break(ev_break_a),
        .ev_repeat(ev_repeat_a), .ev_mods(ev_mods_a), .mods(mods_a),
        .overflow(overflow_a), .ovf_clr(ovf_clr_a));

    kbd_event_decoder #(.DEPTH(4), .HOLDOFF(HO), .REPEAT_EN(0)) dut_b (
        .clk(clk), .clrn(clrn), .ps2_data_in(ps2_data), .ps2_ready(ps2_ready),
        .nextdata_n(nd_b), .ev_valid(ev_valid_b), .ev_ready(ev_ready_b),
        .ev_code(ev_code_b), .ev_ext(ev_ext_b), .ev_break(ev_break_b),
        .ev_repeat(ev_repeat_b), .ev_mods(ev_mods_b), .mods(mods_b),
        .overflow(overflow_b), .ovf_clr(ovf_clr_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int stamp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: key-level state, events as queues of packed {code,ext,brk,rep,mods}
    bit          m_mk [6];
    bit          m_caps;
    bit          m_held_v;
    logic [8:0]  m_held;
    int          m_last;
    bit          m_ovf_a, m_ovf_b;
    logic [14:0] qa[$];
    logic [14:0] qb[$];

    function automatic logic [3:0] m_mods();
        return {m_caps, m_mk[4] | m_mk[5], m_mk[2] | m_mk[3], m_mk[0] | m_mk[1]};
    endfunction

    function automatic int mod_idx(input bit ext, input logic [7:0] code);
        if (!ext && code == 8'h12) return 0;
        if (!ext && code == 8'h59) return 1;
        if (!ext && code == 8'h14) return 2;
        if (ext  && code == 8'h14) return 3;
        if (!ext && code == 8'h11) return 4;
        if (ext  && code == 8'h11) return 5;
        return -1;
    endfunction

    function automatic void push_ev(input bit to_a, input bit to_b, input logic [7:0] code,
                                    input bit ext, input bit brk, input bit rep);
        logic [14:0] e;
        e = {code, ext, brk, rep, m_mods()};
        if (to_a) begin
            if (qa.size() >= 8) m_ovf_a = 1'b1; else qa.push_back(e);
        end
        if (to_b) begin
            if (qb.size() >= 4) m_ovf_b = 1'b1; else qb.push_back(e);
        end
    endfunction

    function automatic void model_key(input bit ext, input bit brk, input logic [7:0] code, input int t);
        int mi;
        bit rep;
        mi = mod_idx(ext, code);
        if (brk) begin
            if (mi >= 0) m_mk[mi] = 1'b0;
            if (m_held_v && m_held == {ext, code}) m_held_v = 1'b0;
            push_ev(1'b1, 1'b1, code, ext, 1'b1, 1'b0);
        end else begin
            rep = m_held_v && (m_held == {ext, code});
            if (mi >= 0) m_mk[mi] = 1'b1;
            if (!rep && !ext && code == 8'h58) m_caps = !m_caps;
            if (!rep) begin
                m_held   = {ext, code};
                m_held_v = 1'b1;
                push_ev(1'b1, 1'b1, code, ext, 1'b0, 1'b0);
                m_last = t;
            end else if (t - m_last > HO) begin
                push_ev(1'b1, 1'b0, code, ext, 1'b0, 1'b1);
                m_last = t;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 6; i++) m_mk[i] = 1'b0;
        m_caps   = 1'b0;
        m_held_v = 1'b0;
        m_held   = 9'h000;
        m_last   = -1000;
        m_ovf_a  = 1'b0;
        m_ovf_b  = 1'b0;
        qa.delete();
        qb.delete();
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        ps2_data  = b;
        ps2_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (nd_a !== 1'b0 && n < 20);
        chk("pop_strobe_a", nd_a, 0);
        chk("pop_strobe_b", nd_b, 0);
        ps2_ready = 1'b0;
        stamp = cyc;
    endtask

    task automatic send_key_raw(input bit ext, input bit brk, input logic [7:0] code);
        if (ext) send_byte(8'hE0);
        if (brk) send_byte(8'hF0);
        send_byte(code);
    endtask

    task automatic drain(input bit which);
        int n;
        logic [14:0] e;
        n = which ? qb.size() : qa.size();
        for (int i = 0; i < n; i++) begin
            e = which ? qb.pop_front() : qa.pop_front();
            chk(which ? "valid_b" : "valid_a", which ? ev_valid_b : ev_valid_a, 1);
            chk(which ? "head_b" : "head_a", which ? head_b : head_a, e);
            if (which) ev_ready_b = 1'b1; else ev_ready_a = 1'b1;
            @(negedge clk);
            ev_ready_a = 1'b0;
            ev_ready_b = 1'b0;
        end
        chk(which ? "empty_b" : "empty_a", which ? ev_valid_b : ev_valid_a, 0);
    endtask

    task automatic settle(input bit drain_b);
        chk("mods_a", mods_a, m_mods());
        chk("mods_b", mods_b, m_mods());
        chk("ovf_a", overflow_a, m_ovf_a);
        chk("ovf_b", overflow_b, m_ovf_b);
        drain(1'b0);
        if (drain_b) drain(1'b1);
    endtask

    task automatic key(input bit ext, input bit brk, input logic [7:0] code);
        send_key_raw(ext, brk, code);
        model_key(ext, brk, code, stamp);
        @(negedge clk);
        settle(1'b1);
    endtask

    task automatic pause_seq();
        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        push_ev(1'b1, 1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        m_last = stamp;
        @(negedge clk);
        settle(1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        ps2_ready = 1'b0;
        #2;
        chk("rst_valid_a", ev_valid_a, 0);
        chk("rst_valid_b", ev_valid_b, 0);
        chk("rst_head_a", head_a, 0);
        chk("rst_mods_a", mods_a, 0);
        chk("rst_ovf_b", overflow_b, 0);
        chk("rst_nd_a", nd_a, 1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    logic [8:0] keys [14] = '{9'h01C, 9'h01B, 9'h023, 9'h012, 9'h059, 9'h014, 9'h011,
                              9'h058, 9'h029, 9'h05A, 9'h175, 9'h16B, 9'h114, 9'h111};
    logic [7:0] junk [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        logic [8:0] k;
        ev_ready_a = 1'b0;
        ev_ready_b = 1'b0;
        ovf_clr_a  = 1'b0;
        ovf_clr_b  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("init_valid", ev_valid_a, 0);
        chk("init_mods", mods_a, 0);
        chk("init_ovf", overflow_a, 0);
        chk("init_nd", nd_a, 1);
        clrn = 1'b1;
        @(negedge clk);

        // First make: one-cycle strobe and one-cycle latency to ev_valid
        send_byte(8'h1C);
        model_key(1'b0, 1'b0, 8'h1C, stamp);
        chk("lat_empty", ev_valid_a, 0);
        @(negedge clk);
        chk("lat_valid", ev_valid_a, 1);
        chk("strobe_one_cycle", nd_a, 1);
        settle(1'b1);
        key(1'b0, 1'b1, 8'h1C);

        // Shifted key
        key(1'b0, 1'b0, 8'h12);
        key(1'b0, 1'b0, 8'h1C);
        key(1'b0, 1'b1, 8'h1C);
        key(1'b0, 1'b1, 8'h12);
        chk("shift_released", mods_a, 4'b0000);

        // Extended keys and fake shift
        key(1'b1, 1'b0, 8'h75);
        key(1'b1, 1'b1, 8'h75);
        send_byte(8'hE0);
        send_byte(8'h12);
        @(negedge clk);
        settle(1'b1);

        // Caps lock toggling
        key(1'b0, 1'b0, 8'h58);
        chk("caps_on", mods_a[3], 1);
        key(1'b0, 1'b1, 8'h58);
        chk("caps_hold", mods_a[3], 1);
        key(1'b0, 1'b0, 8'h58);
        chk("caps_off", mods_a[3], 0);
        key(1'b0, 1'b1, 8'h58);

        pause_seq();

        // Typematic repeats
        for (int i = 0; i < 4; i++) begin
            key(1'b0, 1'b0, 8'h1C);
            idle(5);
        end
        key(1'b0, 1'b1, 8'h1C);

        // Overflow on the 4-deep instance
        for (int i = 0; i < 5; i++) begin
            r = i;
            send_key_raw(1'b0, 1'b0, (r == 0) ? 8'h1C : (r == 1) ? 8'h1B : (r == 2) ? 8'h23 :
                                     (r == 3) ? 8'h2B : 8'h34);
            model_key(1'b0, 1'b0, (r == 0) ? 8'h1C : (r == 1) ? 8'h1B : (r == 2) ? 8'h23 :
                                  (r == 3) ? 8'h2B : 8'h34, stamp);
            @(negedge clk);
            settle(1'b0);
        end
        chk("ovf_set", overflow_b, 1);
        send_byte(8'h1D);
        chk("full_head_b", head_b, qb[0]);
        ev_ready_b = 1'b1;
        void'(qb.pop_front());
        model_key(1'b0, 1'b0, 8'h1D, stamp);
        @(negedge clk);
        ev_ready_b = 1'b0;
        settle(1'b0);
        ovf_clr_b = 1'b1;
        @(negedge clk);
        ovf_clr_b = 1'b0;
        m_ovf_b = 1'b0;
        chk("ovf_cleared", overflow_b, 0);
        drain(1'b1);

        // Reset in the middle of an E0 sequence
        send_byte(8'hE0);
        do_reset();
        key(1'b0, 1'b0, 8'h1C);

        // Randomized key traffic
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            idle($urandom_range(0, 20));
            k = keys[$urandom_range(0, 13)];
            if (r < 40) begin
                key(k[8], 1'b0, k[7:0]);
            end else if (r < 70) begin
                key(k[8], 1'b1, k[7:0]);
            end else if (r < 85) begin
                if (m_held_v) key(m_held[8], 1'b0, m_held[7:0]);
                else key(k[8], 1'b0, k[7:0]);
            end else if (r < 90) begin
                pause_seq();
            end else if (r < 95) begin
                send_byte(junk[$urandom_range(0, 5)]);
                @(negedge clk);
                settle(1'b1);
            end else begin
                send_byte(8'hE0);
                if ($urandom_range(0, 1) == 1) send_byte(8'hF0);
                send_byte(8'h12);
                @(negedge clk);
                settle(1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
